// File: rtl/aes_block_loader.sv
// Loads a 128-bit key and plaintext from a 32-bit word stream, runs aes_top for LATENCY cycles, and returns the ciphertext with a valid/ready handshake.
// Define AES_LOADER_KEY_REUSE_EN to keep the loaded key so that later blocks need only four plaintext words.
module aes_block_loader #(
   parameter int LATENCY = 12
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [31:0]  in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [127:0] core_data,
   output logic [127:0] core_key,
   output logic         core_rst_n,
   input  logic [127:0] core_result,
   output logic [127:0] out_data,
   output logic         out_valid,
   input  logic         out_ready
`ifdef AES_LOADER_KEY_REUSE_EN
   ,
   input  logic         new_key
`endif
);

   if (LATENCY < 1 || LATENCY > 31) begin : g_bad_latency
      $error("aes_block_loader: LATENCY must be in 1..31");
   end

   localparam logic [4:0] LAT = 5'(LATENCY);

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   logic [2:0]  word_cnt;
   logic [4:0]  run_cnt;
   logic        accept;
   logic [6:0]  lane_lsb;
`ifdef AES_LOADER_KEY_REUSE_EN
   logic        key_loaded;
`endif

   assign in_ready = (state == LOAD) && !reset;
   assign accept   = in_valid && in_ready;

   // Word 0 of each group lands in the most-significant lane.
   assign lane_lsb = {~word_cnt[1:0], 5'd0};

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= LOAD;
         word_cnt   <= 3'd0;
         run_cnt    <= 5'd0;
         core_rst_n <= 1'b0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         core_data  <= '0;
         core_key   <= '0;
`ifdef AES_LOADER_KEY_REUSE_EN
         key_loaded <= 1'b0;
`endif
      end else begin
         case (state)
            LOAD: begin
               core_rst_n <= 1'b0;
               if (accept) begin
                  if (word_cnt[2]) begin
                     core_data[lane_lsb +: 32] <= in_data;
                  end else begin
                     core_key[lane_lsb +: 32] <= in_data;
                  end
`ifdef AES_LOADER_KEY_REUSE_EN
                  if (word_cnt == 3'd3) begin
                     key_loaded <= 1'b1;
                  end
`endif
                  if (word_cnt == 3'd7) begin
                     state    <= RUN;
                     word_cnt <= 3'd0;
                     run_cnt  <= 5'd0;
                  end else begin
                     word_cnt <= word_cnt + 3'd1;
                  end
               end
`ifdef AES_LOADER_KEY_REUSE_EN
               else if (new_key && word_cnt == 3'd4) begin
                  key_loaded <= 1'b0;
                  word_cnt   <= 3'd0;
               end
`endif
            end
            // Cycle 0 keeps the core in reset; it then runs for LATENCY cycles.
            RUN: begin
               if (run_cnt == LAT) begin
                  out_data  <= core_result;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  run_cnt    <= run_cnt + 5'd1;
                  core_rst_n <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state      <= LOAD;
                  out_valid  <= 1'b0;
                  core_rst_n <= 1'b0;
                  run_cnt    <= 5'd0;
`ifdef AES_LOADER_KEY_REUSE_EN
                  word_cnt   <= key_loaded ? 3'd4 : 3'd0;
`else
                  word_cnt   <= 3'd0;
`endif
               end
            end
            default: begin
               state <= LOAD;
            end
         endcase
      end
   end

endmodule
